sram_master_ctrl: RTL and testbench

- Bus master that drives the byte-wide, single-port `MEMORY` array from a simple valid/ready request interface.
- Converts each request into the memory's pin-level sequence:
  - `load` to latch the address
  - `write` strobe with `DATA` driven for stores
  - `OE` with `DATA` sampled for loads
- Sits between the CPU/DMA-side request logic and the `MEMORY` instance, and owns the tristate `DATA` bus.

---
 rtl/sram_master_pkg.sv | 29 ++
 rtl/sram_master_ctrl_if.sv | 31 +++
 rtl/sram_wait_cnt.sv | 38 +++
 rtl/sram_master_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sram_master_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_master_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sram_master_pkg : shared types and constants for the SRAM bus master.
// Rev 1.0
// -----------------------------------------------------------------------------
package sram_master_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_LOAD   = 3'd1,
      WR_STROBE = 3'd2,
      WR_REC    = 3'd3,
      RD_OE     = 3'd4,
      RD_CAP    = 3'd5,
      VF_OE     = 3'd6,
      VF_CAP    = 3'd7
   } sram_state_e;

   // The counter is loaded with (cycles - 1), so it only needs to hold max-1.
   function automatic int wait_cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_master_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sram_master_ctrl_if : valid/ready request and response bundle.
// Rev 1.0
// -----------------------------------------------------------------------------
interface sram_master_ctrl_if #(
   parameter int SIZE = 20
);
   import sram_master_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [SIZE-1:0]   req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface
`default_nettype wire

// File: rtl/sram_wait_cnt.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sram_wait_cnt : loadable down-counter, done while the count sits at zero.
// Rev 1.0
// -----------------------------------------------------------------------------
module sram_wait_cnt #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   output logic             done_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = value_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sram_master_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sram_master_ctrl : turns valid/ready requests into SRAM load/write/OE cycles.
// Rev 1.0   Optional: SRAM_MASTER_WRITE_VERIFY_EN adds a read-back compare.
// -----------------------------------------------------------------------------
module sram_master_ctrl
   import sram_master_pkg::*;
#(
   parameter int SIZE       = 20,
   parameter int RD_WAIT    = 1,
   parameter int WR_RECOVER = 0
) (
   input  logic              CLK,
   input  logic              RESET_N,
   sram_master_ctrl_if.slave bus,
   output logic [SIZE-1:0]   ADDRESS,
   output logic              load,
   output logic              write,
   output logic              OE,
   inout  wire  [DATA_W-1:0] DATA
);

   localparam int             CW       = wait_cnt_width(RD_WAIT, WR_RECOVER);
   localparam logic [CW-1:0]  RD_LOAD  = CW'(RD_WAIT - 1);
   localparam logic [CW-1:0]  REC_LOAD = CW'((WR_RECOVER > 0) ? WR_RECOVER - 1 : 0);

`ifdef SRAM_MASTER_WRITE_VERIFY_EN
   localparam bit          VERIFY  = 1'b1;
   localparam sram_state_e POST_WR = VF_OE;
`else
   localparam bit          VERIFY  = 1'b0;
   localparam sram_state_e POST_WR = IDLE;
`endif

   sram_state_e       state_q, state_d;
   logic [SIZE-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              load_q, load_d;
   logic              write_q, write_d;
   logic              oe_q, oe_d;
   logic              cnt_load;
   logic [CW-1:0]     cnt_value;
   logic              cnt_done;
`ifdef SRAM_MASTER_WRITE_VERIFY_EN
   logic              err_q, err_d;
`endif

   sram_wait_cnt #(.WIDTH(CW)) u_wait_cnt (
      .clk_i   (CLK),
      .rst_ni  (RESET_N),
      .load_i  (cnt_load),
      .value_i (cnt_value),
      .done_o  (cnt_done)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;
      cnt_load    = 1'b0;
      cnt_value   = RD_LOAD;
`ifdef SRAM_MASTER_WRITE_VERIFY_EN
      err_d       = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               if (bus.req_write) begin
                  state_d = WR_LOAD;
               end else begin
                  state_d  = RD_OE;
                  cnt_load = 1'b1;
               end
            end
         end
         WR_LOAD: state_d = WR_STROBE;
         WR_STROBE: begin
            // Plain writes respond here; verified writes respond after compare.
            rsp_valid_d = !VERIFY;
            cnt_load    = 1'b1;
            if (WR_RECOVER > 0) begin
               state_d   = WR_REC;
               cnt_value = REC_LOAD;
            end else begin
               state_d = POST_WR;
            end
         end
         WR_REC: begin
            if (cnt_done) begin
               state_d  = POST_WR;
               cnt_load = 1'b1;
            end
         end
         RD_OE: if (cnt_done) state_d = RD_CAP;
         RD_CAP: begin
            rdata_d     = DATA;
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
`ifdef SRAM_MASTER_WRITE_VERIFY_EN
            err_d       = 1'b0;
`endif
         end
`ifdef SRAM_MASTER_WRITE_VERIFY_EN
         VF_OE: if (cnt_done) state_d = VF_CAP;
         VF_CAP: begin
            rdata_d     = DATA;
            err_d       = (DATA != wdata_q);
            rsp_valid_d = 1'b1;
            state_d     = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase

      // Pin strobes are registered from the next state so they align with it.
      ready_d = (state_d == IDLE);
      load_d  = (state_d == WR_LOAD);
      write_d = (state_d == WR_STROBE);
      oe_d    = (state_d == RD_OE) || (state_d == RD_CAP) ||
                (state_d == VF_OE) || (state_d == VF_CAP);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         load_q      <= 1'b0;
         write_q     <= 1'b0;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         load_q      <= load_d;
         write_q     <= write_d;
         oe_q        <= oe_d;
      end
   end

`ifdef SRAM_MASTER_WRITE_VERIFY_EN
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
   assign bus.rsp_err = err_q;
`else
   assign bus.rsp_err = 1'b0;
`endif

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign ADDRESS       = addr_q;
   assign load          = load_q;
   assign write         = write_q;
   assign OE            = oe_q;
   assign DATA          = write_q ? wdata_q : 'z;

endmodule
`default_nettype wire

// File: tb/tb_sram_master_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sram_master_ctrl : directed + random requests against a byte SRAM model.
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_sram_master_ctrl;
   import sram_master_pkg::*;

   localparam int SIZE       = 20;
   localparam int RD_WAIT    = 3;
   localparam int WR_RECOVER = 1;
`ifdef SRAM_MASTER_WRITE_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif
   localparam int WR_LAT   = VERIFY ? (3 + WR_RECOVER + RD_WAIT + 1) : 3;
   localparam int WR_SPACE = VERIFY ? WR_LAT : (3 + WR_RECOVER);
   localparam int RD_LAT   = RD_WAIT + 2;

   logic clk = 1'b0;
   logic rst_n;
   wire  [DATA_W-1:0] DATA;
   logic [SIZE-1:0]   ADDRESS;
   logic              load, write, OE;

   sram_master_ctrl_if #(.SIZE(SIZE)) bus ();

   sram_master_ctrl #(.SIZE(SIZE), .RD_WAIT(RD_WAIT), .WR_RECOVER(WR_RECOVER)) dut (
      .CLK     (clk),
      .RESET_N (rst_n),
      .bus     (bus),
      .ADDRESS (ADDRESS),
      .load    (load),
      .write   (write),
      .OE      (OE),
      .DATA    (DATA)
   );

   always #5 clk = ~clk;

   // SRAM model: address register loaded by load, asynchronous read under OE.
   logic [7:0]      mem [0:(1<<SIZE)-1];
   logic [SIZE-1:0] mem_areg;
   logic [7:0]      stuck_mask = 8'hFF;
   assign DATA = OE ? (mem[ADDRESS] & stuck_mask) : 8'hzz;

   always @(posedge clk) begin
      if (load)  mem_areg = ADDRESS;
      if (write) mem[mem_areg] = DATA;
   end

   // Reference: preload pattern plus every accepted store.
   logic [7:0] ref_mem [int];
   logic [7:0] exp_rdata;

   function automatic logic [7:0] pat(input logic [SIZE-1:0] a);
      return a[7:0] ^ {a[15:12], a[19:16]} ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ref_read(input logic [SIZE-1:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return pat(a);
   endfunction

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pin monitor, sampled mid-cycle.
   int              mon_load, mon_write, mon_oe;
   int              mon_clash = 0, mon_float_bad = 0, mon_rsp = 0;
   logic [7:0]      mon_wdata;
   logic [SIZE-1:0] mon_waddr;

   always @(posedge clk) begin
      #3;
      if (load) mon_load++;
      if (write) begin
         mon_write++;
         mon_wdata = DATA;
         mon_waddr = ADDRESS;
      end
      if (OE) mon_oe++;
      if (write && OE) mon_clash++;
      if (!write && !OE && (DATA !== 8'hzz)) mon_float_bad++;
      if (bus.rsp_valid) mon_rsp++;
   end

   // Issue one request (entered at a negedge) and check it to completion.
   task automatic do_req(input bit wr, input logic [SIZE-1:0] a, input logic [7:0] d, input bit keep);
      int         k, lat, space, seen;
      logic [7:0] exp_rd;
      logic       exp_err;
      lat   = wr ? WR_LAT : RD_LAT;
      space = wr ? WR_SPACE : RD_LAT;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      k = 0;
      while (bus.req_ready !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("accept", 32'(k < 40), 32'd1);
      @(posedge clk);
      #1;
      mon_load = 0; mon_write = 0; mon_oe = 0;
      if (wr) begin
         ref_mem[int'(a)] = d;
         exp_rd  = VERIFY ? (d & stuck_mask) : exp_rdata;
         exp_err = VERIFY && ((d & stuck_mask) != d);
      end else begin
         exp_rd  = ref_read(a) & stuck_mask;
         exp_err = 1'b0;
      end
      seen = 0;
      for (int c = 1; c <= 40 && seen == 0; c++) begin
         @(negedge clk);
         if (c == 1 && !keep) begin
            bus.req_valid = 1'b0;
            bus.req_write = 1'($urandom);
            bus.req_addr  = SIZE'($urandom);
            bus.req_wdata = 8'($urandom);
         end
         check(wr ? "wr_ready" : "rd_ready", 32'(bus.req_ready), 32'(c >= space));
         if (bus.rsp_valid === 1'b1) seen = c;
      end
      check(wr ? "wr_latency" : "rd_latency", seen, lat);
      if (seen != 0) n_done++;
      exp_rdata = exp_rd;
      check("rsp_rdata", bus.rsp_rdata, exp_rd);
      check("rsp_err", bus.rsp_err, exp_err);
      check("load_pulses", mon_load, wr ? 1 : 0);
      check("write_pulses", mon_write, wr ? 1 : 0);
      check("oe_cycles", mon_oe, (wr && !VERIFY) ? 0 : RD_WAIT + 1);
      if (wr) begin
         check("strobe_data", mon_wdata, d);
         check("strobe_addr", mon_waddr, a);
      end
   endtask

   int rsp_before;

   initial begin
      for (int i = 0; i < (1 << SIZE); i++) mem[i] = pat(SIZE'(i));
      exp_rdata     = 8'h00;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_ready", bus.req_ready, 1);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rdata", bus.rsp_rdata, 0);
      check("rst_err", bus.rsp_err, 0);
      check("rst_address", ADDRESS, 0);
      check("rst_strobes", {load, write, OE}, 0);
      check("rst_data_z", 32'(DATA === 8'hzz), 1);
      rst_n = 1'b1;
      @(negedge clk);

      do_req(1'b1, 20'h00010, 8'hA5, 1'b0);
      do_req(1'b0, 20'h00010, 8'h00, 1'b0);
      do_req(1'b0, 20'h00003, 8'h00, 1'b0);

      do_req(1'b1, 20'h00005, 8'h11, 1'b1);
      do_req(1'b0, 20'h00005, 8'h00, 1'b1);
      do_req(1'b1, 20'hFFFFF, 8'h22, 1'b0);
      do_req(1'b0, 20'hFFFFF, 8'h00, 1'b0);

      // Reset while the write strobe is on the bus.
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 20'h00040;
      bus.req_wdata = 8'h99;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_reset_write", write, 1);
      rsp_before = mon_rsp;
      rst_n = 1'b0;
      #1;
      check("arst_strobes", {load, write, OE}, 0);
      check("arst_data_z", 32'(DATA === 8'hzz), 1);
      check("arst_ready", bus.req_ready, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("aborted_no_rsp", mon_rsp, rsp_before);
      exp_rdata = 8'h00;
      check("arst_rdata", bus.rsp_rdata, 0);
      do_req(1'b0, 20'h00007, 8'h00, 1'b0);

`ifdef SRAM_MASTER_WRITE_VERIFY_EN
      do_req(1'b1, 20'h00020, 8'h3C, 1'b0);
      stuck_mask = 8'hF7;
      do_req(1'b1, 20'h00020, 8'h3C, 1'b0);
      stuck_mask = 8'hFF;
      check("stuck_rdata", bus.rsp_rdata, 8'h34);
`endif

      for (int i = 0; i < 24; i++) begin
         logic [SIZE-1:0] a;
         a = ($urandom_range(0, 3) == 0) ? (20'h80000 | SIZE'($urandom))
                                         : (20'h00100 + SIZE'($urandom_range(0, 15)));
         do_req(1'($urandom_range(0, 1)), a, 8'($urandom), 1'($urandom_range(0, 1)));
      end
      bus.req_valid = 1'b0;
      repeat (8) @(negedge clk);

      check("write_oe_clash", mon_clash, 0);
      check("data_driven_idle", mon_float_bad, 0);
      check("rsp_pulse_total", mon_rsp, n_done);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
